// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU stage arbiter.
// Covers slot states, requester indices and the response flag bit positions.
package alu_arb_pkg;

  localparam int NUM_REQ = 2;
  localparam int REQ_EXE = 0;
  localparam int REQ_AGU = 1;

  // Bit positions inside the 4-bit response flag field.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic v, input logic c);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    return f;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// 2-way round-robin arbiter: grant is combinational from eligible, zero latency.
// last_grant moves only on an actual grant, so idle or stalled cycles keep the order.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] eligible,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = 2'b00;
    unique case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (|grant) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/alu_stage_arbiter.sv
// Shares one ALU stage between two requesters; the response is registered 1 cycle after the grant.
// A requester waits while its response slot is full and undrained; hold stalls grants only.
module alu_stage_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         hold,
  input  logic [1:0]                   req_valid,
  output logic [1:0]                   req_ready,
  input  logic [1:0]                   req_ALUSrc,
  input  logic [1:0]                   req_dOrImm,
  input  logic [1:0][8:0]              req_dAddr9,
  input  logic [1:0][11:0]             req_imm12,
  input  logic [1:0][2:0]              req_ALUOp,
  input  logic [1:0][DATA_W-1:0]       req_A,
  input  logic [1:0][DATA_W-1:0]       req_B,
  output logic                         alu_ALUSrc,
  output logic                         alu_dOrImm,
  output logic [8:0]                   alu_dAddr9,
  output logic [11:0]                  alu_imm12,
  output logic [2:0]                   alu_ALUOp,
  output logic [DATA_W-1:0]            alu_A,
  output logic [DATA_W-1:0]            alu_ReadData2,
  input  logic [DATA_W-1:0]            alu_result,
  input  logic                         alu_negative,
  input  logic                         alu_zero,
  input  logic                         alu_overflow,
  input  logic                         alu_carry_out,
  output logic [1:0]                   rsp_valid,
  input  logic [1:0]                   rsp_ready,
  output logic [1:0][DATA_W-1:0]       rsp_result,
  output logic [1:0][3:0]              rsp_flags
);

  slot_state_e slot_q [NUM_REQ];
  slot_state_e slot_d [NUM_REQ];
  logic [1:0]  drain;
  logic [1:0]  eligible;
  logic [1:0]  grant;

  always_comb begin
    drain    = 2'b00;
    eligible = 2'b00;
    rsp_valid = 2'b00;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = (slot_q[i] == SLOT_FULL);
      drain[i]     = rsp_valid[i] & rsp_ready[i];
      // Reset gating keeps req_ready and the ALU inputs quiet during the reset cycle.
      eligible[i]  = req_valid[i] & ~hold & ~reset &
                     ((slot_q[i] == SLOT_EMPTY) | drain[i]);
    end
  end

  rr_arbiter2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .eligible (eligible),
    .grant    (grant)
  );

  assign req_ready = grant;

  always_comb begin
    alu_ALUSrc    = 1'b0;
    alu_dOrImm    = 1'b0;
    alu_dAddr9    = '0;
    alu_imm12     = '0;
    alu_ALUOp     = '0;
    alu_A         = '0;
    alu_ReadData2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        alu_ALUSrc    = req_ALUSrc[i];
        alu_dOrImm    = req_dOrImm[i];
        alu_dAddr9    = req_dAddr9[i];
        alu_imm12     = req_imm12[i];
        alu_ALUOp     = req_ALUOp[i];
        alu_A         = req_A[i];
        alu_ReadData2 = req_B[i];
      end
    end
  end

  // A grant wins over a drain so a slot drained and regranted in one cycle stays full.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      slot_d[i] = slot_q[i];
      if (grant[i]) begin
        slot_d[i] = SLOT_FULL;
      end else if (drain[i]) begin
        slot_d[i] = SLOT_EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_q[i]     <= SLOT_EMPTY;
        rsp_result[i] <= '0;
        rsp_flags[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_q[i] <= slot_d[i];
        if (grant[i]) begin
          rsp_result[i] <= alu_result;
          rsp_flags[i]  <= pack_flags(alu_negative, alu_zero, alu_overflow, alu_carry_out);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_stage_arbiter.sv
// Directed bench for alu_stage_arbiter with a behavioural ALU stage and per-requester scoreboards.
module tb_alu_stage_arbiter;

  logic              clk = 1'b0;
  logic              reset;
  logic              hold;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_ALUSrc;
  logic [1:0]        req_dOrImm;
  logic [1:0][8:0]   req_dAddr9;
  logic [1:0][11:0]  req_imm12;
  logic [1:0][2:0]   req_ALUOp;
  logic [1:0][63:0]  req_A;
  logic [1:0][63:0]  req_B;
  logic              alu_ALUSrc;
  logic              alu_dOrImm;
  logic [8:0]        alu_dAddr9;
  logic [11:0]       alu_imm12;
  logic [2:0]        alu_ALUOp;
  logic [63:0]       alu_A;
  logic [63:0]       alu_ReadData2;
  logic [63:0]       alu_result;
  logic              alu_negative;
  logic              alu_zero;
  logic              alu_overflow;
  logic              alu_carry_out;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [1:0][63:0]  rsp_result;
  logic [1:0][3:0]   rsp_flags;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_ORR = 3'd3;

  typedef struct packed {
    logic [3:0]  flg;
    logic [63:0] res;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic [1:0] exp_full;
  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  alu_stage_arbiter #(.DATA_W(64)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ALUSrc(req_ALUSrc), .req_dOrImm(req_dOrImm), .req_dAddr9(req_dAddr9),
    .req_imm12(req_imm12), .req_ALUOp(req_ALUOp), .req_A(req_A), .req_B(req_B),
    .alu_ALUSrc(alu_ALUSrc), .alu_dOrImm(alu_dOrImm), .alu_dAddr9(alu_dAddr9),
    .alu_imm12(alu_imm12), .alu_ALUOp(alu_ALUOp), .alu_A(alu_A),
    .alu_ReadData2(alu_ReadData2), .alu_result(alu_result),
    .alu_negative(alu_negative), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .alu_carry_out(alu_carry_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags)
  );

  // Behavioural ALU stage: B is the register operand, or a sign-extended dAddr9 / zero-extended imm12.
  function automatic exp_t alu_model(input logic src, input logic dorimm, input logic [8:0] daddr,
                                     input logic [11:0] imm, input logic [2:0] op,
                                     input logic [63:0] a, input logic [63:0] rd2);
    logic [63:0] b;
    logic [64:0] s;
    logic v;
    exp_t r;
    b = src ? (dorimm ? {52'd0, imm} : {{55{daddr[8]}}, daddr}) : rd2;
    s = '0;
    v = 1'b0;
    case (op)
      OP_ADD: begin s = {1'b0, a} + {1'b0, b};       v = (a[63] == b[63]) && (s[63] != a[63]); end
      OP_SUB: begin s = {1'b0, a} + {1'b0, ~b} + 65'd1; v = (a[63] != b[63]) && (s[63] != a[63]); end
      OP_AND: s = {1'b0, a & b};
      OP_ORR: s = {1'b0, a | b};
      default: s = '0;
    endcase
    r.res = s[63:0];
    r.flg = {s[63], (s[63:0] == 64'd0), v, s[64]};
    return r;
  endfunction

  always_comb begin
    exp_t r;
    r = alu_model(alu_ALUSrc, alu_dOrImm, alu_dAddr9, alu_imm12, alu_ALUOp, alu_A, alu_ReadData2);
    alu_result    = r.res;
    alu_negative  = r.flg[3];
    alu_zero      = r.flg[2];
    alu_overflow  = r.flg[1];
    alu_carry_out = r.flg[0];
  end

  task automatic check(input string tag, input logic [67:0] got, input logic [67:0] want);
    total++;
    assert (got === want) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, want);
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic src, input logic dorimm,
                         input logic [8:0] daddr, input logic [11:0] imm);
    req_ALUOp[i]  = op;
    req_A[i]      = a;
    req_B[i]      = b;
    req_ALUSrc[i] = src;
    req_dOrImm[i] = dorimm;
    req_dAddr9[i] = daddr;
    req_imm12[i]  = imm;
  endtask

  // One clock cycle: check grant, pop/compare drained responses, push accepted requests.
  task automatic tick(input logic [1:0] exp_ready, input string tag);
    logic [1:0] hs;
    exp_t e;
    #1;
    check({tag, " req_ready"}, {66'd0, req_ready}, {66'd0, exp_ready});
    check({tag, " rsp_valid"}, {66'd0, rsp_valid}, {66'd0, exp_full});
    hs = req_valid & req_ready;
    for (int i = 0; i < 2; i++) begin
      if (rsp_valid[i] && rsp_ready[i]) begin
        if ((i == 0 ? q0.size() : q1.size()) == 0) begin
          check({tag, " unexpected rsp"}, {67'd0, 1'b1}, 68'd0);
        end else begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          check({tag, " rsp"}, {rsp_flags[i], rsp_result[i]}, {e.flg, e.res});
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (hs[i]) begin
        e = alu_model(req_ALUSrc[i], req_dOrImm[i], req_dAddr9[i], req_imm12[i],
                      req_ALUOp[i], req_A[i], req_B[i]);
        if (i == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
    @(posedge clk);
    if (reset) begin
      exp_full = 2'b00;
      q0.delete();
      q1.delete();
    end else begin
      exp_full = hs | (exp_full & ~(rsp_valid & rsp_ready));
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2'b00, "reset");
    reset = 1'b0;
  endtask

  initial begin
    logic [63:0] held;
    reset = 1'b1; hold = 1'b0; req_valid = 2'b11; rsp_ready = 2'b00;
    req_ALUSrc = '0; req_dOrImm = '0; req_dAddr9 = '0; req_imm12 = '0;
    req_ALUOp = '0; req_A = '0; req_B = '0; exp_full = 2'b00;
    set_req(0, OP_ADD, 64'd7, 64'd9, 1'b0, 1'b0, 9'd0, 12'd0);
    set_req(1, OP_ADD, 64'd4, 64'd6, 1'b0, 1'b0, 9'd0, 12'd0);
    @(posedge clk); #1;

    // Reset state, including quiet ALU inputs while requests are valid
    #1;
    check("rst alu_A", {4'd0, alu_A}, 68'd0);
    check("rst alu_ReadData2", {4'd0, alu_ReadData2}, 68'd0);
    tick(2'b00, "rst");
    check("rst rsp_result0", {4'd0, rsp_result[0]}, 68'd0);
    check("rst rsp_flags1", {64'd0, rsp_flags[1]}, 68'd0);
    reset = 1'b0;

    // Single ADD on requester 0
    req_valid = 2'b01; rsp_ready = 2'b11;
    set_req(0, OP_ADD, 64'd5, 64'd3, 1'b0, 1'b0, 9'd0, 12'd0);
    tick(2'b01, "add");
    check("add rsp_valid0", {67'd0, rsp_valid[0]}, 68'd1);
    check("add result", {4'd0, rsp_result[0]}, 68'd8);
    check("add flags", {64'd0, rsp_flags[0]}, 68'd0);
    req_valid = 2'b00;
    tick(2'b00, "add drain");

    // Alternation from reset with both requesting every cycle
    do_reset();
    req_valid = 2'b11;
    set_req(0, OP_ADD, 64'd1, 64'd2, 1'b0, 1'b0, 9'd0, 12'd0);
    set_req(1, OP_AND, 64'hF0F0, 64'hFF00, 1'b0, 1'b0, 9'd0, 12'd0);
    tick(2'b01, "rr0");
    tick(2'b10, "rr1");
    tick(2'b01, "rr2");
    tick(2'b10, "rr3");

    // Back-to-back throughput on a single requester
    req_valid = 2'b01;
    set_req(0, OP_ORR, 64'h0F, 64'hF0, 1'b0, 1'b0, 9'd0, 12'd0);
    tick(2'b01, "tp0");
    tick(2'b01, "tp1");
    tick(2'b01, "tp2");

    // Requester 1 SUB with its response held back; requester 0 keeps flowing
    req_valid = 2'b10; rsp_ready = 2'b01;
    set_req(1, OP_SUB, 64'd3, 64'd5, 1'b0, 1'b0, 9'd0, 12'd0);
    tick(2'b10, "sub");
    check("sub result", {4'd0, rsp_result[1]}, {4'd0, 64'hFFFF_FFFF_FFFF_FFFE});
    check("sub negative", {67'd0, rsp_flags[1][3]}, 68'd1);
    held = rsp_result[1];
    req_valid = 2'b11;
    set_req(1, OP_ADD, 64'd100, 64'd1, 1'b0, 1'b0, 9'd0, 12'd0);
    for (int k = 0; k < 4; k++) begin
      tick(2'b01, "sub wait");
      check("sub held", {4'd0, rsp_result[1]}, {4'd0, held});
    end
    rsp_ready = 2'b11;
    tick(2'b10, "sub release");
    tick(2'b01, "post release");

    // Hold stalls grants; pending response still drains; order resumes
    hold = 1'b1;
    tick(2'b00, "hold0");
    tick(2'b00, "hold1");
    tick(2'b00, "hold2");
    hold = 1'b0;
    tick(2'b10, "resume0");
    tick(2'b01, "resume1");

    // Reset the cycle after a grant: no stale response, order restarts at 0
    req_valid = 2'b01;
    tick(2'b01, "pre-rst grant");
    rsp_ready = 2'b00; req_valid = 2'b00;
    do_reset();
    rsp_ready = 2'b11;
    tick(2'b00, "post-rst idle0");
    tick(2'b00, "post-rst idle1");
    req_valid = 2'b11;
    tick(2'b01, "post-rst rr0");
    tick(2'b10, "post-rst rr1");

    // Immediate path: B is still the register operand toward the ALU stage
    req_valid = 2'b10;
    set_req(1, OP_ADD, 64'd10, 64'hDEAD_BEEF, 1'b1, 1'b0, 9'h1FF, 12'd0);
    #1;
    check("imm ReadData2", {4'd0, alu_ReadData2}, {4'd0, 64'hDEAD_BEEF});
    check("imm dAddr9", {59'd0, alu_dAddr9}, {59'd0, 9'h1FF});
    tick(2'b10, "imm");
    check("imm result", {4'd0, rsp_result[1]}, 68'd9);
    req_valid = 2'b00;
    tick(2'b00, "final0");
    tick(2'b00, "final1");
    check("q0 empty", {4'd0, 64'(q0.size())}, 68'd0);
    check("q1 empty", {4'd0, 64'(q1.size())}, 68'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
